// File: rtl/mp_regfile.sv
// Multi-port GPR file: NUM_RD combinational read ports, NUM_WR byte-masked write ports,
// optional same-cycle bypass, per-byte youngest-port-wins conflict resolution.
module mp_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic [NUM_WR*DATA_W/8-1:0] wr_be,
  output logic                       wr_conflict
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0][DATA_W-1:0] mem_nxt;
  logic [NUM_WR-1:0]            wr_live;
  logic                         conflict_nxt;

  // Post-edge image of every register; walking ports in ascending order lets the
  // highest-numbered (youngest) port win each byte it enables.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    mem_nxt = mem;
    for (int r = 0; r < DEPTH; r++) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
          for (int b = 0; b < NB; b++) begin
            if (wr_be[w*NB + b])
              mem_nxt[r][b*8 +: 8] = wr_data[w*DATA_W + b*8 +: 8];
          end
        end
      end
    end
    if (ZERO_REG != 0)
      mem_nxt[0] = '0;
  end

  // A collision needs two ports that would each really change a nonzero register.
  always_comb begin
    conflict_nxt = 1'b0;
    for (int w = 0; w < NUM_WR; w++)
      wr_live[w] = wr_en[w] && (|wr_be[w*NB +: NB]);
    for (int a = 0; a < NUM_WR; a++) begin
      for (int b = a + 1; b < NUM_WR; b++) begin
        if (wr_live[a] && wr_live[b] &&
            wr_addr[a*ADDR_W +: ADDR_W] == wr_addr[b*ADDR_W +: ADDR_W] &&
            wr_addr[a*ADDR_W +: ADDR_W] != '0)
          conflict_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [ADDR_W-1:0] idx;
      idx = rd_addr[i*ADDR_W +: ADDR_W];
      if (rst || (ZERO_REG != 0 && idx == '0))
        rd_data[i*DATA_W +: DATA_W] = '0;
      else if (BYPASS != 0)
        rd_data[i*DATA_W +: DATA_W] = mem_nxt[idx];
      else
        rd_data[i*DATA_W +: DATA_W] = mem[idx];
    end
  end

  // NOTE: the storage array is flop-based and reset as a whole because the
  // architectural GPR state must read zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      mem         <= '0;
      wr_conflict <= 1'b0;
    end else begin
      mem         <= mem_nxt;
      wr_conflict <= conflict_nxt;
    end
  end

endmodule

// File: tb/tb_mp_regfile.sv
// Self-checking bench for mp_regfile: directed scenarios plus a random phase,
// expected read data queued at drive time and compared when sampled.
module tb_mp_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int NW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR*AW-1:0]  rd_addr = '0;
  logic [NR*DW-1:0]  rd_data;
  logic [NR*DW-1:0]  rd_data_nb;
  logic [NW-1:0]     wr_en = '0;
  logic [NW*AW-1:0]  wr_addr = '0;
  logic [NW*DW-1:0]  wr_data = '0;
  logic [NW*DW/8-1:0] wr_be = '0;
  logic              wr_conflict;
  logic              wr_conflict_nb;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [32];
  logic        exp_conf;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  mp_regfile #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_conflict(wr_conflict)
  );

  mp_regfile #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_conflict(wr_conflict_nb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference value register `a` holds after the coming edge, given current inputs.
  function automatic logic [31:0] post_edge(input logic [4:0] a);
    logic [31:0] v;
    v = model[a];
    for (int b = 0; b < 4; b++) begin
      for (int w = NW - 1; w >= 0; w--) begin
        if (wr_en[w] && wr_be[w*4 + b] && wr_addr[w*AW +: AW] == a) begin
          v[b*8 +: 8] = wr_data[w*DW + b*8 +: 8];
          break;
        end
      end
    end
    return (a == 5'd0) ? 32'h0 : v;
  endfunction

  function automatic logic collision();
    return wr_en[0] && wr_en[1] && (|wr_be[3:0]) && (|wr_be[7:4]) &&
           wr_addr[4:0] == wr_addr[9:5] && wr_addr[4:0] != 5'd0;
  endfunction

  // One clock cycle, entered and left at posedge+1.
  task automatic cyc(input logic [1:0] en,
                     input logic [4:0] a0, input logic [31:0] d0, input logic [3:0] b0,
                     input logic [4:0] a1, input logic [31:0] d1, input logic [3:0] b1,
                     input logic [19:0] ra);
    logic [31:0] nxt [32];
    logic        nxt_conf;
    logic [4:0]  r0;
    wr_en   = en;
    wr_addr = {a1, a0};
    wr_data = {d1, d0};
    wr_be   = {b1, b0};
    rd_addr = ra;
    for (int i = 0; i < NR; i++)
      exp_q.push_back(post_edge(ra[i*AW +: AW]));
    r0 = ra[4:0];
    exp_q.push_back((r0 == 5'd0) ? 32'h0 : model[r0]);
    exp_q.push_back({31'd0, exp_conf});
    for (int r = 0; r < 32; r++)
      nxt[r] = post_edge(5'(r));
    nxt_conf = collision();
    @(negedge clk);
    for (int i = 0; i < NR; i++)
      check($sformatf("rd%0d", i), rd_data[i*DW +: DW], exp_q.pop_front());
    check("nb_rd0", rd_data_nb[31:0], exp_q.pop_front());
    check("conflict", {31'd0, wr_conflict}, exp_q.pop_front());
    @(posedge clk);
    for (int r = 0; r < 32; r++)
      model[r] = nxt[r];
    exp_conf = nxt_conf;
    #1;
  endtask

  task automatic rd4(input logic [4:0] a);
    cyc(2'b00, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 4'h0, {a, a, a, a});
  endtask

  initial begin
    for (int r = 0; r < 32; r++)
      model[r] = 32'h0;
    exp_conf = 1'b0;
    #12;
    check("rst_rd0", rd_data[31:0], 32'h0);
    check("rst_conflict", {31'd0, wr_conflict}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset contents across the index range.
    cyc(2'b00, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 4'h0, {5'd31, 5'd17, 5'd1, 5'd0});

    // Basic write with same-cycle bypass; non-bypass instance lags one cycle.
    cyc(2'b01, 5'd5, 32'h12341234, 4'hF, 5'd0, 32'h0, 4'h0, {5'd5, 5'd5, 5'd5, 5'd5});
    rd4(5'd5);

    // Register zero stays zero and a collision on it does not flag.
    cyc(2'b11, 5'd0, 32'hDEADBEEF, 4'hF, 5'd0, 32'hDEADBEEF, 4'hF, {5'd0, 5'd0, 5'd0, 5'd0});
    rd4(5'd0);

    // Byte-enable merge.
    cyc(2'b01, 5'd7, 32'hAABBCCDD, 4'hF, 5'd0, 32'h0, 4'h0, {5'd7, 5'd7, 5'd7, 5'd7});
    cyc(2'b01, 5'd7, 32'h11223344, 4'h3, 5'd0, 32'h0, 4'h0, {5'd7, 5'd7, 5'd7, 5'd7});
    check("merge_model", model[7], 32'hAABB3344);
    rd4(5'd7);

    // Dual-write conflict: per-byte youngest port wins, flag for one cycle.
    cyc(2'b11, 5'd9, 32'h00000001, 4'hF, 5'd9, 32'hFFFF0000, 4'hC, {5'd9, 5'd9, 5'd9, 5'd9});
    cyc(2'b00, 5'd0, 32'h0, 4'h0, 5'd0, 32'h0, 4'h0, {5'd9, 5'd9, 5'd9, 5'd9});
    check("conflict_val", rd_data[31:0], 32'hFFFF0001);
    check("conflict_one_cycle", {31'd0, wr_conflict}, 32'h0);
    rd4(5'd9);

    // Enabled write with all byte enables clear is a no-op and never collides.
    cyc(2'b11, 5'd9, 32'h12345678, 4'h0, 5'd9, 32'h87654321, 4'h0, {5'd9, 5'd9, 5'd9, 5'd9});
    rd4(5'd9);

    // Async reset while a write is pending.
    cyc(2'b01, 5'd3, 32'h00000055, 4'hF, 5'd0, 32'h0, 4'h0, {5'd3, 5'd3, 5'd3, 5'd3});
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd3};
    wr_data = {32'h0, 32'h00000099};
    wr_be   = 8'h0F;
    rd_addr = {5'd3, 5'd3, 5'd3, 5'd3};
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_rd", rd_data[31:0], 32'h0);
    check("rst_mid_nb_rd", rd_data_nb[31:0], 32'h0);
    check("rst_mid_conflict", {31'd0, wr_conflict}, 32'h0);
    for (int r = 0; r < 32; r++)
      model[r] = 32'h0;
    exp_conf = 1'b0;
    @(negedge clk);
    wr_en = 2'b00;
    rst   = 1'b0;
    @(posedge clk);
    #1;
    rd4(5'd3);
    cyc(2'b01, 5'd3, 32'h00000066, 4'hF, 5'd0, 32'h0, 4'h0, {5'd3, 5'd3, 5'd3, 5'd3});
    rd4(5'd3);

    // Random traffic on a narrow index window to provoke collisions and r0 hits.
    for (int n = 0; n < 80; n++) begin
      cyc(2'($urandom_range(0, 3)),
          5'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)),
          5'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)),
          {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
